// File: rtl/red_seq_ctrl.sv
// rtl/red_seq_ctrl.sv - multi-cycle nibble-sum reduction sequencer sharing one nibble adder
// Optional build macro RED_SEQ_DUAL_EN: two nibbles per ACC cycle (two adders, half the cycles).
module red_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int RES_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] rd
);

  localparam int NIB = 2 * WIDTH / 4;
`ifdef RED_SEQ_DUAL_EN
  localparam int STEPS     = NIB / 2;
  localparam int STEP_BITS = 8;
`else
  localparam int STEPS     = NIB;
  localparam int STEP_BITS = 4;
`endif
  localparam int CNT_W = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] shift_q;
  logic [RES_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RES_W-1:0]   step_sum;
  logic               accept;
  logic               last_step;

`ifdef RED_SEQ_DUAL_EN
  assign step_sum = RES_W'(shift_q[3:0]) + RES_W'(shift_q[7:4]);
`else
  assign step_sum = RES_W'(shift_q[3:0]);
`endif

  assign accept    = in_valid && in_ready && !kill;
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));
  assign rd        = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // kill overrides every handshake, including a result transfer in DONE
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = ACC;
        ACC:     if (last_step) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // acc survives in IDLE so rd keeps the last result until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (kill) begin
      if (state != IDLE) acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      shift_q <= {rt, rs};
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (state == ACC) begin
      acc_q   <= acc_q + step_sum;
      shift_q <= shift_q >> STEP_BITS;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_red_seq_ctrl.sv
// tb/tb_red_seq_ctrl.sv - self-checking bench for red_seq_ctrl
module tb_red_seq_ctrl;
  localparam int NIB = 8;
`ifdef RED_SEQ_DUAL_EN
  localparam int STEPS = NIB / 2;
`else
  localparam int STEPS = NIB;
`endif
  localparam int NPS = NIB / STEPS;
  localparam int LAT = STEPS + 1;
  localparam int RST_AT = (STEPS >= 5) ? 5 : STEPS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rs;
  logic [15:0] rt;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  rd;

  int checks = 0;
  int failures = 0;

  red_seq_ctrl #(.WIDTH(16), .RES_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [6:0]  exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // sum of the first n nibbles of {b,a}, lowest nibble first
  function automatic int nib_sum(input logic [15:0] a, input logic [15:0] b, input int n);
    logic [31:0] v;
    int s;
    v = {b, a};
    s = 0;
    for (int i = 0; i < n; i++) s += int'(v[4*i +: 4]);
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [15:0] a, input logic [15:0] b);
    rs = a;
    rt = b;
    in_valid = 1'b1;
    chk("accept_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input logic [15:0] a, input logic [15:0] b, input logic [6:0] exp_rd);
    int  n;
    logic busy_ok;
    accept_op(a, b);
    chk("rd_cleared_on_accept", rd, 0);
    busy_ok = 1'b1;
    n = 1;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      n++;
    end
    chk("in_ready_low_while_busy", busy_ok, 1);
    chk("latency", n, LAT);
    chk("rd_result", rd, exp_rd);
    chk("in_ready_low_in_done", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_after_transfer", in_ready, 1);
    chk("out_valid_low_after_transfer", out_valid, 0);
    chk("rd_held_after_transfer", rd, exp_rd);
  endtask

  task automatic no_result_window(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk(name, seen, 0);
  endtask

  int m_phase, m_k, m_rd, n;
  logic [15:0] m_a, m_b;

  initial begin
    vecs[0] = '{16'hFFFF, 16'hFFFF, 7'd120};
    vecs[1] = '{16'h1234, 16'h0000, 7'd10};
    vecs[2] = '{16'h0000, 16'h0000, 7'd0};
    vecs[3] = '{16'hFFFF, 16'h0F0F, 7'd90};
    vecs[4] = '{16'h00FF, 16'hF000, 7'd45};
    vecs[5] = '{16'h0001, 16'h8000, 7'd9};

    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    rs = '0; rt = '0;
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rd", rd, 0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i].a, vecs[i].b, vecs[i].exp_rd);

    // backpressure: result must hold for 6 stalled cycles
    accept_op(16'hFFFF, 16'hFFFF);
    wait_valid(n);
    chk("bp_latency", n, LAT);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_rd_held", rd, 120);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_after_release", in_ready, 1);

    // kill in the 3rd ACC cycle
    accept_op(16'h1234, 16'h5678);
    tick();
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_acc_in_ready", in_ready, 1);
    chk("kill_acc_rd", rd, 0);
    no_result_window("kill_acc_no_result");

    // kill together with out_ready in DONE
    accept_op(16'h0F0F, 16'h0101);
    wait_valid(n);
    chk("kd_rd_before", rd, nib_sum(16'h0F0F, 16'h0101, NIB));
    kill = 1'b1;
    out_ready = 1'b1;
    tick();
    kill = 1'b0;
    out_ready = 1'b0;
    chk("kill_done_in_ready", in_ready, 1);
    chk("kill_done_out_valid", out_valid, 0);
    chk("kill_done_rd", rd, 0);

    // kill in IDLE blocks the accept
    rs = 16'hAAAA; rt = 16'h5555;
    in_valid = 1'b1;
    kill = 1'b1;
    tick();
    in_valid = 1'b0;
    kill = 1'b0;
    chk("kill_idle_in_ready", in_ready, 1);
    no_result_window("kill_idle_no_result");

    // async reset in the middle of ACC
    accept_op(16'hFFFF, 16'hFFFF);
    for (int i = 1; i < RST_AT; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_rd", rd, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(16'hBEEF, 16'hCAFE, 7'(nib_sum(16'hBEEF, 16'hCAFE, NIB)));

    // randomized traffic against a phase/partial-sum reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m_phase = 0; m_k = 0; m_rd = 0; m_a = '0; m_b = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      rs        = 16'($urandom);
      rt        = 16'($urandom);
      kill      = (m_phase != 0) && ($urandom_range(0, 15) == 0);
      chk("rnd_in_ready", in_ready, (m_phase == 0));
      chk("rnd_out_valid", out_valid, (m_phase == 2));
      chk("rnd_rd", rd, m_rd);
      tick();
      if (kill) begin
        m_rd = 0;
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (in_valid) begin
               m_a = rs; m_b = rt; m_k = 0; m_rd = 0; m_phase = 1;
             end
          1: begin
               m_k++;
               m_rd = nib_sum(m_a, m_b, m_k * NPS);
               if (m_k == STEPS) m_phase = 2;
             end
          default: if (out_ready) m_phase = 0;
        endcase
      end
    end
    in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
